// File: rtl/mem_stream_reader.sv
// Read-side sequencer for the pattern word memory. It issues a wrap-around run
// of read addresses and streams the returned words over valid/ready with a 2-entry buffer.
module mem_stream_reader #(
    parameter  int DEPTH  = 16,
    parameter  int LENGTH = 11,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [LENGTH-1:0] rd_data,
    output logic [LENGTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, next_state;
    logic [ADDR_W:0]     run_len;
    logic [ADDR_W:0]     issue_left;
    logic [ADDR_W-1:0]   addr_inc;
    logic                in_flight;
    logic                in_flight_last;
    logic [1:0]          occ;
    logic [LENGTH-1:0]   data0, data1;
    logic                last0, last1;
    logic                xfer, issue_ok, issue, accept, finish, zero_start;
    logic [2:0]          load;

    assign run_len   = (count > DEPTH_CNT) ? DEPTH_CNT : count;
    assign out_valid = (occ != 2'd0);
    assign out_data  = data0;
    assign out_last  = last0;
    assign xfer      = out_valid & out_ready;

    // Slots committed after this edge: buffered + landing read, minus the word leaving now.
    assign load     = {1'b0, occ} + {2'b00, in_flight} - {2'b00, xfer};
    assign issue_ok = (load < 3'd2);
    // Explicit wrap compare so non-power-of-two depths wrap correctly.
    assign addr_inc = (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        accept     = 1'b0;
        issue      = 1'b0;
        finish     = 1'b0;
        zero_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        accept     = 1'b1;
                        next_state = (run_len == CNT_ONE) ? DRAIN : RUN;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue_ok) begin
                    issue = 1'b1;
                    if (issue_left == CNT_ONE) next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!in_flight && (occ == 2'd0 || (occ == 2'd1 && xfer))) begin
                    finish     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffer is only two registers, so it is reset too; this keeps
            // out_data/out_last at 0 after reset instead of leaking stale words.
            rd_addr        <= '0;
            issue_left     <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            occ            <= 2'd0;
            data0          <= '0;
            data1          <= '0;
            last0          <= 1'b0;
            last1          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done      <= finish | zero_start;
            in_flight <= accept | issue;
            if (accept) begin
                rd_addr        <= base_addr;
                issue_left     <= run_len - 1'b1;
                in_flight_last <= (run_len == CNT_ONE);
                busy           <= 1'b1;
            end else if (issue) begin
                rd_addr        <= addr_inc;
                issue_left     <= issue_left - 1'b1;
                in_flight_last <= (issue_left == CNT_ONE);
            end
            if (finish) busy <= 1'b0;

            case ({in_flight, xfer})
                2'b10: begin
                    if (occ == 2'd0) begin
                        data0 <= rd_data;
                        last0 <= in_flight_last;
                    end else begin
                        data1 <= rd_data;
                        last1 <= in_flight_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    data0 <= data1;
                    last0 <= last1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        data0 <= rd_data;
                        last0 <= in_flight_last;
                    end else begin
                        data0 <= data1;
                        last0 <= last1;
                        data1 <= rd_data;
                        last1 <= in_flight_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
